// File: rtl/noc_fabric_pkg.sv
// Shared definitions for the NoC traffic node: flit field layout helpers,
// LFSR constants and the packet-generator state encoding.
package noc_fabric_pkg;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } gen_state_e;

    // Flit layout: {last, dest[addr_w], payload[data_w]}
    function automatic int unsigned flit_w(input int unsigned data_w, input int unsigned addr_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int unsigned last_pos(input int unsigned data_w, input int unsigned addr_w);
        return data_w + addr_w;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded with SEED in reset.
module noc_lfsr16
    import noc_fabric_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/noc_fabric.sv
// NoC traffic node: generates PACKS_TO_GEN random packets towards the switch
// and counts complete packets arriving from it.
module noc_fabric
    import noc_fabric_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned ADDR         = 0,
    parameter int unsigned NODES_NUM    = 16,
    parameter int unsigned PACKS_TO_GEN = 10,
    parameter int unsigned MAX_PACK_LEN = 4,
    parameter int unsigned DEBUG        = 0,
    parameter int unsigned FREQ         = 4
) (
    input  logic                         clk,
    input  logic                         a_rst,
    input  logic [DATA_SIZE+ADDR_SIZE:0] data_i,
    input  logic                         wr_ready_in,
    output logic                         r_ready_out,
    output logic [DATA_SIZE+ADDR_SIZE:0] data_o,
    output logic                         wr_ready_out,
    input  logic                         r_ready_in,
    output logic [31:0]                  recv_packs
);

    localparam int unsigned FLIT_W   = flit_w(DATA_SIZE, ADDR_SIZE);
    localparam int unsigned LAST_BIT = last_pos(DATA_SIZE, ADDR_SIZE);
    localparam int unsigned CNT_W    = $clog2(FREQ + 1);
    localparam int unsigned LEN_W    = $clog2(MAX_PACK_LEN + 1);
    localparam int unsigned SENT_W   = $clog2(PACKS_TO_GEN + 2);

    gen_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SENT_W-1:0]     sent_q;
    logic [LEN_W-1:0]      idx_q;
    logic [LEN_W-1:0]      idx_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      len_d;
    logic [ADDR_SIZE-1:0]  dest_q;
    logic [ADDR_SIZE-1:0]  dest_d;
    logic [FLIT_W-1:0]     data_q;
    logic                  wr_ready_q;
    logic                  r_ready_q;
    logic [31:0]           recv_q;
    logic [31:0]           recv_d;
    logic                  recv_inc_c;
    logic                  wrap_c;
    logic                  latch_c;
    logic [LFSR_W-1:0]     lfsr;
    logic [31:0]           dest_raw;
    logic [31:0]           dest_sel;
    logic                  unused_data_bits;

    noc_lfsr16 #(
        .SEED(LFSR_SEED ^ LFSR_W'(ADDR))
    ) u_lfsr (
        .clk   (clk),
        .rst_i (a_rst),
        .lfsr_o(lfsr)
    );

    // Packet parameters drawn from the LFSR; a self-addressed pick is bumped to the next node
    always_comb begin
        dest_raw = 32'(lfsr) % NODES_NUM;
        dest_sel = dest_raw;
        if (dest_raw == ADDR) begin
            dest_sel = (NODES_NUM == 1) ? 32'd0 : (ADDR + 1) % NODES_NUM;
        end
        dest_d  = ADDR_SIZE'(dest_sel);
        len_d   = LEN_W'(32'(lfsr) % MAX_PACK_LEN + 32'd1);
        idx_d   = idx_q + LEN_W'(1);
        wrap_c  = (state_q == ST_IDLE) && (cnt_q == CNT_W'(FREQ - 1));
        latch_c = wrap_c && (sent_q < SENT_W'(PACKS_TO_GEN));
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sent_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            dest_q     <= '0;
            data_q     <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wrap_c) begin
                        cnt_q <= '0;
                        if (latch_c) begin
                            state_q    <= ST_SEND;
                            dest_q     <= dest_d;
                            len_q      <= len_d;
                            idx_q      <= '0;
                            wr_ready_q <= 1'b1;
                            data_q     <= {len_d == LEN_W'(1), dest_d, DATA_SIZE'(ADDR)};
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (r_ready_in) begin
                        if (data_q[LAST_BIT]) begin
                            state_q    <= ST_IDLE;
                            wr_ready_q <= 1'b0;
                            sent_q     <= sent_q + SENT_W'(1);
                            cnt_q      <= '0;
                        end else begin
                            idx_q  <= idx_d;
                            data_q <= {idx_d == (len_q - LEN_W'(1)), dest_q, DATA_SIZE'(idx_d)};
                        end
                    end
                end
                ST_DONE: begin
                    wr_ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Receiver never back-pressures; only the last bit matters for counting
    always_comb begin
        recv_inc_c = wr_ready_in && r_ready_q && data_i[LAST_BIT] && (recv_q != 32'hFFFF_FFFF);
        recv_d     = recv_inc_c ? recv_q + 32'd1 : recv_q;
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_ready_q <= 1'b0;
            recv_q    <= '0;
        end else begin
            r_ready_q <= 1'b1;
            recv_q    <= recv_d;
        end
    end

    assign unused_data_bits = ^data_i[LAST_BIT-1:0];

    if (DEBUG != 0) begin : g_debug
        always_ff @(posedge clk) begin
            if (!a_rst && latch_c) begin
                $display("node %0d: send packet dest=%0d len=%0d", ADDR, dest_d, len_d);
            end
            if (!a_rst && recv_inc_c) begin
                $display("node %0d: packet received, recv_packs=%0d", ADDR, recv_d);
            end
        end
    end

    assign data_o       = data_q;
    assign wr_ready_out = wr_ready_q;
    assign r_ready_out  = r_ready_q;
    assign recv_packs   = recv_q;

endmodule

// File: tb/tb_noc_fabric.sv
// Directed bench for noc_fabric: generator traffic, back-pressure, receive counting,
// mid-packet reset, and a fast FREQ=1 / single-flit instance.
module tb_noc_fabric;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned FW    = DW + AW + 1;
    localparam int unsigned PACKS = 3;
    localparam int unsigned MAXL  = 4;
    localparam int unsigned FRQ   = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          a_rst;
    logic [FW-1:0] data_i;
    logic          wr_ready_in;
    logic          r_ready_in;
    logic          r_ready_out, wr_ready_out;
    logic [FW-1:0] data_o;
    logic [31:0]   recv_packs;
    logic          f_r_ready_out, f_wr_ready_out;
    logic [FW-1:0] f_data_o;
    logic [31:0]   f_recv_packs;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m;
    logic [15:0] m_prev;

    always #5 clk = ~clk;

    noc_fabric #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .ADDR(0), .NODES_NUM(4),
        .PACKS_TO_GEN(PACKS), .MAX_PACK_LEN(MAXL), .DEBUG(0), .FREQ(FRQ)
    ) u_dut (
        .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
        .r_ready_out(r_ready_out), .data_o(data_o), .wr_ready_out(wr_ready_out),
        .r_ready_in(r_ready_in), .recv_packs(recv_packs)
    );

    noc_fabric #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .ADDR(0), .NODES_NUM(4),
        .PACKS_TO_GEN(3), .MAX_PACK_LEN(1), .DEBUG(0), .FREQ(1)
    ) u_fast (
        .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
        .r_ready_out(f_r_ready_out), .data_o(f_data_o), .wr_ready_out(f_wr_ready_out),
        .r_ready_in(1'b1), .recv_packs(f_recv_packs)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // ADDR=0 with 4 nodes: a pick of 0 becomes node 1
    function automatic logic [3:0] exp_dest(input logic [15:0] l);
        int unsigned d = 32'(l) % 4;
        if (d == 0) d = 1;
        return 4'(d);
    endfunction

    function automatic int unsigned exp_len(input logic [15:0] l);
        return 32'(l) % MAXL + 1;
    endfunction

    function automatic logic [31:0] exp_flit(input int unsigned idx, input int unsigned len,
                                             input logic [3:0] dst);
        logic [7:0] pl = (idx == 0) ? 8'h00 : 8'(idx);
        return {19'd0, (idx == len - 1), dst, pl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge; the reference LFSR tracks the DUT's, m_prev is the value used at this edge
    task automatic tick();
        @(posedge clk);
        m_prev = m;
        m = a_rst ? SEED : lfsr_step(m);
        #1;
    endtask

    // Runs the generator from just after reset until DONE, with one 5-cycle stall on packet 2
    task automatic run_send();
        int          sent = 0;
        int          fidx = 0;
        int          len = 0;
        int          idle_run = 0;
        int          stall = 0;
        bit          stalled = 1'b0;
        bit          in_pkt = 1'b0;
        bit          pend_acc = 1'b0;
        bit          pend_last = 1'b0;
        logic [3:0]  dst = '0;
        r_ready_in = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) chk("r_ready_up", 32'(r_ready_out), 32'd1);
            if (k <= 8) begin
                chk("fast_wr", 32'(f_wr_ready_out), 32'((k % 2 == 1) && (k <= 5)));
                if (f_wr_ready_out) chk("fast_flit", 32'(f_data_o), {19'd0, 1'b1, exp_dest(m_prev), 8'h00});
            end
            if (pend_acc) begin
                if (pend_last) begin
                    in_pkt   = 1'b0;
                    sent++;
                    idle_run = 0;
                end else begin
                    fidx++;
                end
            end
            pend_acc = 1'b0;
            if (in_pkt || wr_ready_out) begin
                if (!in_pkt) begin
                    chk("gap", 32'(idle_run), (sent == 0) ? FRQ - 1 : FRQ);
                    len    = exp_len(m_prev);
                    dst    = exp_dest(m_prev);
                    fidx   = 0;
                    in_pkt = 1'b1;
                    chk("dest_nz", 32'(data_o[DW+AW-1:DW] != 4'd0), 32'd1);
                end
                chk("wr_hold", 32'(wr_ready_out), 32'd1);
                chk("flit", 32'(data_o), exp_flit(fidx, len, dst));
                if (sent == 1 && fidx == 0 && !stalled) begin
                    stall   = 5;
                    stalled = 1'b1;
                end
                if (stall > 0) begin
                    r_ready_in = 1'b0;
                    stall--;
                end else begin
                    r_ready_in = 1'b1;
                    pend_acc   = 1'b1;
                    pend_last  = (fidx == len - 1);
                end
            end else begin
                idle_run++;
            end
        end
        chk("sent_total", 32'(sent), PACKS);
        chk("done_wr", 32'(wr_ready_out), 32'd0);
        chk("fast_done_wr", 32'(f_wr_ready_out), 32'd0);
    endtask

    initial begin
        a_rst       = 1'b1;
        r_ready_in  = 1'b1;
        wr_ready_in = 1'b0;
        data_i      = '0;
        tick();
        tick();
        chk("rst_wr", 32'(wr_ready_out), 32'd0);
        chk("rst_rr", 32'(r_ready_out), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_recv", recv_packs, 32'd0);
        chk("rst_fast_wr", 32'(f_wr_ready_out), 32'd0);
        a_rst = 1'b0;

        run_send();

        // Receive: two body flits then a last flit
        wr_ready_in = 1'b1;
        data_i      = {1'b0, 4'd0, 8'hA5};
        tick();
        chk("rx_body1", recv_packs, 32'd0);
        tick();
        chk("rx_body2", recv_packs, 32'd0);
        data_i = {1'b1, 4'd0, 8'h5A};
        tick();
        chk("rx_last", recv_packs, 32'd1);
        chk("rx_fast", f_recv_packs, 32'd1);

        // Last flit present but not offered
        wr_ready_in = 1'b0;
        tick();
        tick();
        tick();
        chk("rx_no_valid", recv_packs, 32'd1);
        wr_ready_in = 1'b1;
        tick();
        chk("rx_second", recv_packs, 32'd2);
        wr_ready_in = 1'b0;
        data_i      = '0;

        // Reset, let a packet start, then reset while its first flit is still pending
        a_rst      = 1'b1;
        r_ready_in = 1'b0;
        tick();
        a_rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mr_wr_pre", 32'(wr_ready_out), 32'd1);
        chk("mr_flit_pre", 32'(data_o), exp_flit(0, exp_len(m_prev), exp_dest(m_prev)));
        a_rst = 1'b1;
        tick();
        chk("mr_wr", 32'(wr_ready_out), 32'd0);
        chk("mr_recv", recv_packs, 32'd0);
        chk("mr_data", 32'(data_o), 32'd0);
        chk("mr_rr", 32'(r_ready_out), 32'd0);
        a_rst = 1'b0;

        run_send();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
